// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - INST_WIDTH          : instruction word width (fixed at 32, four bytes)
//   - DEFAULT_ADDR_WIDTH  : default word-address width of the instruction memory
//   - state_t             : loader state encoding (3 bits)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int INST_WIDTH         = 32;
    localparam int DEFAULT_ADDR_WIDTH = 18;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHKRX = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
// Little-endian 4-byte word assembler shared by payload and checksum reception.
// Byte index k (0..3) lands in bits [8k+7:8k]; the index wraps after the 4th byte.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_clr        : hold index and partial word at zero
//   i_accept     : a byte is consumed this cycle
//   i_byte       : byte being consumed
//   o_word       : assembled word including the byte currently presented
//   o_complete   : the byte consumed this cycle completes a word
// -----------------------------------------------------------------------------
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_accept,
    input  logic [7:0]            i_byte,
    output logic [INST_WIDTH-1:0] o_word,
    output logic                  o_complete
);

    logic [1:0]            r_idx;
    logic [INST_WIDTH-1:0] r_word;

    // The word with the current byte merged in lets the parent register the
    // finished word on the same edge that consumes the last byte.
    always_comb begin
        o_word                     = r_word;
        o_word[{r_idx, 3'b000} +: 8] = i_byte;
    end

    assign o_complete = i_accept && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_word <= o_word;
            r_idx  <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program image from a byte stream into instruction memory: assembles
// little-endian bytes into 32-bit words and writes one word per instruction,
// starting at word address BASE_WORD.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, a 4-byte
// little-endian checksum (sum of written words mod 2^32) follows the payload
// and chk_err reports a mismatch together with done.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, len_words      : load request (sampled in IDLE) and word count
//   byte_in, byte_valid   : incoming stream
//   byte_ready            : byte accepted this cycle when byte_valid is high
//   mem_we/waddr/wdata    : instruction memory word write port
//   busy                  : high outside IDLE
//   done                  : one-cycle pulse at end of load
//   err                   : one-cycle pulse for a rejected start (out of range)
//   chk_err               : checksum mismatch, valid with done
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INST_WIDTH_LENGTH = INST_WIDTH,
    parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
    parameter int BASE_WORD         = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          len_words,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_waddr,
    output logic [INST_WIDTH_LENGTH-1:0] mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         chk_err
);

    localparam logic [ADDR_WIDTH+1:0] DEPTH  = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] BASE_X = (ADDR_WIDTH+2)'(BASE_WORD);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_WORD);

    state_t                 r_state;
    logic [ADDR_WIDTH:0]    r_len;
    logic [ADDR_WIDTH:0]    r_count;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [INST_WIDTH-1:0]  r_wdata;
    logic                   r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INST_WIDTH-1:0]  r_sum;
    logic                   r_chk_err;
`endif

    logic                   w_accept;
    logic                   w_complete;
    logic [INST_WIDTH-1:0]  w_word;
    logic [ADDR_WIDTH+1:0]  w_end;
    logic                   w_reject;
    logic [ADDR_WIDTH:0]    w_count_inc;
    logic [ADDR_WIDTH-1:0]  w_addr;

    // Handshake outputs decode from state only: no path from byte_valid.
    assign byte_ready = (r_state == S_RECV) || (r_state == S_CHKRX);
    assign mem_we     = (r_state == S_WRITE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign mem_waddr  = r_waddr;
    assign mem_wdata  = r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_err    = r_chk_err;
`else
    assign chk_err    = 1'b0;
`endif

    assign w_accept    = byte_valid && byte_ready;
    // Extra headroom bit so the end address compare cannot overflow.
    assign w_end       = BASE_X + {1'b0, len_words};
    assign w_reject    = (w_end > DEPTH);
    assign w_count_inc = r_count + (ADDR_WIDTH+1)'(1);
    assign w_addr      = BASE_A + r_count[ADDR_WIDTH-1:0];

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == S_IDLE),
        .i_accept   (w_accept),
        .i_byte     (byte_in),
        .o_word     (w_word),
        .o_complete (w_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= '0;
            r_chk_err <= 1'b0;
`endif
        end else begin
            r_err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_len   <= len_words;
                            r_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_sum   <= '0;
                            r_state <= (len_words == '0) ? S_CHKRX : S_RECV;
`else
                            r_state <= (len_words == '0) ? S_DONE : S_RECV;
`endif
                        end
                    end
                end
                S_RECV: begin
                    if (w_complete) begin
                        r_waddr <= w_addr;
                        r_wdata <= w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + w_word;
`endif
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                    if (w_count_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state <= S_CHKRX;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_state <= S_RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHKRX: begin
                    if (w_complete) begin
                        r_chk_err <= (w_word != r_sum);
                        r_state   <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (ADDR_WIDTH=18, BASE_WORD=0). Expected
// writes, checksum result and done timing come from the word list of each load.
// Honors IMEM_LOADER_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW   = 18;
    localparam int BASE = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len_words;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          chk_err;

    imem_loader #(
        .INST_WIDTH_LENGTH (32),
        .ADDR_WIDTH        (AW),
        .BASE_WORD         (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed-write log
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            done_cnt, err_cnt, ovl_cnt;
    int            done_cyc, last_we_cyc, last_acc_cyc;
    logic          done_chk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
            last_we_cyc = cyc;
            if (byte_ready) ovl_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_chk = chk_err;
        end
        if (err) err_cnt++;
    end

    task automatic mon_clear();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        ovl_cnt  = 0;
        done_chk = 1'b0;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents one byte after `gap` idle cycles and holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit acc;
        int c;
        int n;
        ok = 1'b1;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = byte_ready;
            c   = cyc;
            @(posedge clk);
            #1;
            if (acc) begin
                last_acc_cyc = c;
                break;
            end
            n++;
            if (n >= 40) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    logic [31:0] pay_q[$];

    // One complete load of pay_q[0..len-1]; chk_good selects the correct sum as
    // checksum, otherwise chkval is sent.
    task automatic run_load(input string tag, input int len, input bit chk_good,
                            input logic [31:0] chkval, input int gap_max,
                            input bit gap_fixed, input bit poke);
        logic [31:0] sum;
        logic [31:0] w;
        logic [31:0] cv;
        int          st_cyc;
        int          g;
        int          n;
        bit          ok;
        bit          all_ok;

        mon_clear();
        sum = 32'h0;
        for (int i = 0; i < len; i++) sum = sum + pay_q[i];
        cv = chk_good ? sum : chkval;

        start     = 1'b1;
        len_words = (AW+1)'(len);
        st_cyc    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_t1"}, busy, 1);
        check({tag, ".err_t1"}, err, 0);
        check({tag, ".ready_t1"}, byte_ready, (len != 0) || CHK);

        all_ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            w = pay_q[i];
            for (int k = 0; k < 4; k++) begin
                if (poke && i == 0 && k == 2) begin
                    start     = 1'b1;
                    len_words = (AW+1)'($urandom_range(7, 1));
                end
                g = gap_fixed ? gap_max : $urandom_range(gap_max, 0);
                send_byte(w[8*k +: 8], g, ok);
                start = 1'b0;
                if (!ok) all_ok = 1'b0;
            end
        end
        if (CHK) begin
            for (int k = 0; k < 4; k++) begin
                g = gap_fixed ? gap_max : $urandom_range(gap_max, 0);
                send_byte(cv[8*k +: 8], g, ok);
                if (!ok) all_ok = 1'b0;
            end
        end
        byte_valid = 1'b0;
        check({tag, ".handshake"}, all_ok, 1);

        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".done_seen"}, done_cnt, 1);
        check({tag, ".n_writes"}, wa_q.size(), len);
        for (int i = 0; i < len && i < wa_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), wa_q[i], AW'(BASE + i));
            check($sformatf("%s.data%0d", tag, i), wd_q[i], pay_q[i]);
        end
        check({tag, ".err_none"}, err_cnt, 0);
        check({tag, ".ready_in_write"}, ovl_cnt, 0);
        check({tag, ".chk_err"}, done_chk, CHK && (cv != sum));
        check({tag, ".busy_end"}, busy, 0);
        if (!CHK && len > 0)
            check({tag, ".done_after_we"}, done_cyc, last_we_cyc + 1);
        if (CHK)
            check({tag, ".done_after_chk"}, done_cyc, last_acc_cyc + 1);
        if (gap_max == 0)
            check({tag, ".latency"}, done_cyc, st_cyc + 1 + 5 * len + (CHK ? 4 : 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len;
        logic [31:0] w;

        rst        = 1'b1;
        start      = 1'b0;
        len_words  = '0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        mon_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst.byte_ready", byte_ready, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_waddr", mem_waddr, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.chk_err", chk_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-word program, valid held high, good checksum
        pay_q = '{32'h00000513, 32'h00100093};
        run_load("basic", 2, 1'b0, 32'h001005A6, 0, 1'b1, 1'b0);

        // Same program, valid toggling, zero checksum (mismatch when enabled)
        run_load("toggle", 2, 1'b0, 32'h00000000, 1, 1'b1, 1'b0);

        // Out-of-range request is rejected
        mon_clear();
        start     = 1'b1;
        len_words = (AW+1)'(32'h40001);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("reject.err_t1", err, 1);
        check("reject.busy_t1", busy, 0);
        check("reject.ready_t1", byte_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        check("reject.err_pulses", err_cnt, 1);
        check("reject.n_writes", wa_q.size(), 0);
        check("reject.busy_end", busy, 0);
        check("reject.done_cnt", done_cnt, 0);

        // Largest legal request is accepted, then aborted by reset
        mon_clear();
        start     = 1'b1;
        len_words = (AW+1)'(32'h40000);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("full.err_t1", err, 0);
        check("full.busy_t1", busy, 1);
        reset_dut();
        check("full.busy_after_rst", busy, 0);
        check("full.err_pulses", err_cnt, 0);

        // Reset in the middle of a word, then a fresh single-word load
        mon_clear();
        start     = 1'b1;
        len_words = (AW+1)'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h11, 0, ok);
        send_byte(8'h22, 0, ok);
        byte_valid = 1'b0;
        reset_dut();
        check("midrst.busy", busy, 0);
        check("midrst.n_writes", wa_q.size(), 0);
        pay_q = '{32'hDDCCBBAA};
        run_load("after_rst", 1, 1'b1, 32'h0, 0, 1'b1, 1'b0);

        // Zero-length load
        pay_q.delete();
        run_load("len0", 0, 1'b1, 32'h0, 0, 1'b1, 1'b0);

        // start pulsed mid-RECV is ignored
        pay_q = '{32'($urandom), 32'($urandom)};
        run_load("poke", 2, 1'b1, 32'h0, 0, 1'b1, 1'b1);

        // Randomized loads
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(5, 1);
            pay_q.delete();
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                pay_q.push_back(w);
            end
            run_load($sformatf("rand%0d", it), len, 1'($urandom_range(1, 0)),
                     32'($urandom) | 32'h1, $urandom_range(3, 0), 1'b0,
                     1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
